snd_beep_gen: RTL
=================

// Module: snd_beep_gen
// PURPOSE
//  Square-wave tone source for the sound-DAC serializer (spi_dac, sound channel).
//  - A start pulse plays a tone of programmable pitch, amplitude and length.
//  - Emits one 8-bit offset-binary sample per sample tick.
//  - Drives the serializer's valid/data inputs; its ready input is the serializer's synca_n.
//  - Ends every tone with one mid-scale sample so the DAC output parks at 0x80.
// PARAMETERS
//  SAMPLE_DIV  2500   clk cycles per sample tick (20 kHz at 50 MHz); must be >= 2
//  MID         8'h80  mid-scale (silence) code
// PORTS
//  clk           in   1   system clock; the block has this one clock only
//  reset_n       in   1   asynchronous, active-low reset
//  i_start       in   1   one-cycle start request
//  i_half_period in   12  tone half-period, in samples; 0 is treated as 1
//  i_duration    in   16  tone length, in samples; 0 means the start is ignored
//  i_amplitude   in   7   peak deviation from MID
//  i_abort       in   1   one-cycle request to stop the tone
//  i_dac_ready   in   1   1 = serializer idle (synca_n high)
//  o_sample      out  8   sample to the serializer (data_spi)
//  o_valid       out  1   one-cycle strobe: o_sample is to be sent
//  o_busy        out  1   tone or tail sample in progress
//  o_miss_cnt    out  8   saturating count of samples overwritten before they were sent
// BEHAVIOUR
//  Reset values: o_sample=MID, o_valid=0, o_busy=0, o_miss_cnt=0; tick counter=0; state=IDLE.
//   Reset acts immediately, mid-tone included, and drops any pending sample.
//  Tick: free-running counter 0..SAMPLE_DIV-1. tick=1 on the cycle the counter equals SAMPLE_DIV-1.
//  States:
//   IDLE: on i_start & ~i_abort & i_duration!=0
//    - latch half=max(i_half_period,1), dur=i_duration, amp=i_amplitude
//    - phase=0, pol=1, state->PLAY; o_busy=1 from the next cycle
//    - i_start with i_duration=0 or with i_abort high in the same cycle: ignored
//   PLAY: on each tick
//    - sample = pol ? MID+amp : MID-amp (8-bit, no overflow: range 0x01..0xFF)
//    - set pending; phase++; when phase==half-1: phase=0, pol=~pol
//    - dur--; when dur reaches 0 -> TAIL
//   PLAY, i_abort high: -> TAIL at once; a sample still pending is kept and sent.
//   TAIL: on the next tick, sample=MID and set pending (tail flagged).
//    - when the tail sample's o_valid is issued: state->IDLE, o_busy=0 on the next cycle
//   i_start while not IDLE: ignored. i_abort in IDLE or TAIL: no effect.
//  Handshake:
//   - pending & i_dac_ready -> o_valid=1 for exactly one cycle, o_sample stable; pending cleared.
//   - o_valid is registered. First valid: 1 cycle after the first tick following start, if ready.
//   - tick while still pending: the new sample overwrites the old one; o_miss_cnt++ (holds at 255).
//   - o_sample holds its last sent value between strobes; it is MID after the tail.
//  o_miss_cnt is cleared only by reset.
// TESTING (bench uses SAMPLE_DIV=4)
//  1. ready=1; start half=2 dur=6 amp=0x10 -> 7 strobes, 4 clk apart:
//     90,90,70,70,90,90,80; busy falls after strobe 7.
//  2. start dur=0 -> no strobe; busy stays 0. Start+abort in the same cycle -> the same.
//  3. amp=0x7F, half=0 -> samples alternate FF,01,FF,...; no wrap past 0xFF or below 0x01.
//  4. ready held 0 across 2 ticks mid-tone -> miss_cnt=1.
//     On ready rise: one strobe carrying the newer sample.
//  5. abort after strobe 2 of test 1 -> next strobe is 80, then busy=0; start mid-tone is ignored.
//  6. reset_n low mid-tone -> o_valid=0, o_busy=0, o_sample=80 asynchronously;
//     no strobe until a new start.

Source files
------------

// File: rtl/snd_beep_gen.sv
// Square-wave tone source for the sound-channel DAC serializer.
// Produces one offset-binary sample per tick and always ends a tone on mid-scale.
module snd_beep_gen #(
    parameter int          SAMPLE_DIV = 2500,
    parameter logic [7:0]  MID        = 8'h80
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_start,
    input  logic [11:0] i_half_period,
    input  logic [15:0] i_duration,
    input  logic [6:0]  i_amplitude,
    input  logic        i_abort,
    input  logic        i_dac_ready,
    output logic [7:0]  o_sample,
    output logic        o_valid,
    output logic        o_busy,
    output logic [7:0]  o_miss_cnt
);

    localparam int             CW        = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0]  TICK_LAST = CW'(SAMPLE_DIV - 1);

    // FLUSH: tail sample generated but still waiting for the serializer
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        TAIL  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [CW-1:0] tick_cnt;
    logic         tick;

    logic [11:0]  half_q, half_d;
    logic [15:0]  dur_q, dur_d;
    logic [6:0]   amp_q, amp_d;
    logic [11:0]  phase_q, phase_d;
    logic         pol_q, pol_d;

    logic         pend_q, pend_d;
    logic [7:0]   pend_data_q, pend_data_d;
    logic         pend_tail_q, pend_tail_d;

    logic [7:0]   sample_q, sample_d;
    logic         valid_q, valid_d;
    logic [7:0]   miss_q, miss_d;

    logic         gen;
    logic [7:0]   gen_data;
    logic         gen_tail;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            half_q      <= 12'd1;
            dur_q       <= '0;
            amp_q       <= '0;
            phase_q     <= '0;
            pol_q       <= 1'b1;
            pend_q      <= 1'b0;
            pend_data_q <= MID;
            pend_tail_q <= 1'b0;
            sample_q    <= MID;
            valid_q     <= 1'b0;
            miss_q      <= '0;
        end else begin
            state_q     <= state_d;
            half_q      <= half_d;
            dur_q       <= dur_d;
            amp_q       <= amp_d;
            phase_q     <= phase_d;
            pol_q       <= pol_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            pend_tail_q <= pend_tail_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            miss_q      <= miss_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        half_d      = half_q;
        dur_d       = dur_q;
        amp_d       = amp_q;
        phase_d     = phase_q;
        pol_d       = pol_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        pend_tail_d = pend_tail_q;
        sample_d    = sample_q;
        valid_d     = 1'b0;
        miss_d      = miss_q;
        gen         = 1'b0;
        gen_data    = MID;
        gen_tail    = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start && !i_abort && (i_duration != 16'd0)) begin
                    half_d  = (i_half_period == 12'd0) ? 12'd1 : i_half_period;
                    dur_d   = i_duration;
                    amp_d   = i_amplitude;
                    phase_d = '0;
                    pol_d   = 1'b1;
                    state_d = PLAY;
                end
            end
            PLAY: begin
                // Abort wins over a coincident tick; the tail follows on the next tick
                if (i_abort) begin
                    state_d = TAIL;
                end else if (tick) begin
                    gen      = 1'b1;
                    gen_data = pol_q ? (MID + {1'b0, amp_q}) : (MID - {1'b0, amp_q});
                    if (phase_q == (half_q - 12'd1)) begin
                        phase_d = '0;
                        pol_d   = ~pol_q;
                    end else begin
                        phase_d = phase_q + 12'd1;
                    end
                    dur_d = dur_q - 16'd1;
                    if (dur_q == 16'd1) begin
                        state_d = TAIL;
                    end
                end
            end
            TAIL: begin
                if (tick) begin
                    gen      = 1'b1;
                    gen_data = MID;
                    gen_tail = 1'b1;
                    state_d  = FLUSH;
                end
            end
            default: begin
            end
        endcase

        // A fresh sample goes straight out when the serializer is idle, else it waits
        if (gen) begin
            if (pend_q && (miss_q != 8'hFF)) begin
                miss_d = miss_q + 8'd1;
            end
            if (i_dac_ready) begin
                valid_d  = 1'b1;
                sample_d = gen_data;
                pend_d   = 1'b0;
                if (gen_tail) begin
                    state_d = IDLE;
                end
            end else begin
                pend_d      = 1'b1;
                pend_data_d = gen_data;
                pend_tail_d = gen_tail;
            end
        end else if (pend_q && i_dac_ready) begin
            valid_d  = 1'b1;
            sample_d = pend_data_q;
            pend_d   = 1'b0;
            if (pend_tail_q) begin
                state_d = IDLE;
            end
        end
    end

    assign o_sample   = sample_q;
    assign o_valid    = valid_q;
    assign o_busy     = (state_q != IDLE);
    assign o_miss_cnt = miss_q;

endmodule
